rand_num: RTL and testbench



---
 rtl/rand_pkg.sv | 22 ++
 rtl/rand_num_step.sv | 9 +
 rtl/rand_num.sv | 33 +++
 tb/tb_rand_num.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// rand_pkg: LFSR constants, step function and direction codes shared by rand_num and maze_carver.
package rand_pkg;
  localparam int LFSR_W = 32;
  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;
  typedef logic [LFSR_W-1:0] lfsr_t;
  localparam lfsr_t DEFAULT_SEED = 32'hACE1_2024;
  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;
  // x^32+x^22+x^2+x+1, Fibonacci form: feedback enters at bit 0
  function automatic lfsr_t lfsr_step(input lfsr_t s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction
  // an all-zero seed would lock the LFSR forever
  function automatic lfsr_t eff_seed(input lfsr_t seed);
    return (seed == '0) ? lfsr_t'(1) : seed;
  endfunction
endpackage

// File: rtl/rand_num_step.sv
// rand_num_step: one combinational LFSR step.
module rand_num_step
  import rand_pkg::*;
(
  input  lfsr_t cur,
  output lfsr_t nxt
);
  assign nxt = lfsr_step(cur);
endmodule

// File: rtl/rand_num.sv
// rand_num: free-running 2-bit direction source, 32-bit LFSR advanced two steps per clock.
// The output is named rand_code because rand is a reserved word.
module rand_num
  import rand_pkg::*;
#(
  parameter lfsr_t SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] rand_code
);
  localparam lfsr_t SEED_EFF = eff_seed(SEED);
  if (SEED == '0) begin : g_zero_seed
    $warning("rand_num: SEED of zero replaced by 1");
  end
  lfsr_t s;
  lfsr_t s1;
  lfsr_t s2;
  rand_num_step u_step_a (.cur(s),  .nxt(s1));
  rand_num_step u_step_b (.cur(s1), .nxt(s2));
  // zero state is unreachable normally; reload the seed to escape lockup
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s         <= SEED_EFF;
      rand_code <= DIR_RIGHT;
    end else if (s == '0) begin
      s         <= SEED_EFF;
      rand_code <= DIR_RIGHT;
    end else begin
      s         <= s2;
      rand_code <= s2[1:0];
    end
endmodule

// File: tb/tb_rand_num.sv
// tb_rand_num: directed checks of reset, known sequence, async reset, lockup, model and distribution.
module tb_rand_num;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       reset_d = 1'b0;
  logic [1:0] rand_code;
  logic [1:0] rand_d;
  int passed = 0;
  int total = 0;
  logic [1:0] exp_seq [3] = '{2'b10, 2'b11, 2'b01};

  always #5 clk = ~clk;

  rand_num #(.SEED(32'h1)) dut (.clk(clk), .reset(reset), .rand_code(rand_code));
  rand_num dut_d (.clk(clk), .reset(reset_d), .rand_code(rand_d));

  task automatic test_reset();
    reset = 1'b0;
    reset_d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (rand_code !== 2'b00) $display("FAIL reset_rand edge %0d: got %b want 00", i, rand_code);
      else passed++;
      total++;
      if (dut.s !== 32'h1) $display("FAIL reset_state edge %0d: got %h want 00000001", i, dut.s);
      else passed++;
    end
    total++;
    if (dut_d.s !== 32'hACE1_2024) $display("FAIL reset_default_seed: got %h want ace12024", dut_d.s);
    else passed++;
  endtask

  task automatic test_known();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (rand_code !== exp_seq[i]) $display("FAIL known_seq edge %0d: got %b want %b", i + 1, rand_code, exp_seq[i]);
      else passed++;
    end
    total++;
    if (dut.s !== 32'h6D) $display("FAIL known_state: got %h want 0000006d", dut.s);
    else passed++;
  endtask

  task automatic test_async_reset();
    repeat (100) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (rand_code !== 2'b00) $display("FAIL async_rand: got %b want 00", rand_code);
    else passed++;
    total++;
    if (dut.s !== 32'h1) $display("FAIL async_state: got %h want 00000001", dut.s);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (rand_code !== exp_seq[i]) $display("FAIL async_restart edge %0d: got %b want %b", i + 1, rand_code, exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_lockup();
    repeat (7) @(posedge clk);
    @(negedge clk);
    force dut.s = 32'h0;
    #1 release dut.s;
    @(posedge clk);
    #1;
    total++;
    if (dut.s !== 32'h1) $display("FAIL lockup_state: got %h want 00000001", dut.s);
    else passed++;
    total++;
    if (rand_code !== 2'b00) $display("FAIL lockup_rand: got %b want 00", rand_code);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (rand_code !== exp_seq[i]) $display("FAIL lockup_seq edge %0d: got %b want %b", i + 1, rand_code, exp_seq[i]);
      else passed++;
    end
  endtask

  task automatic test_model();
    logic [31:0] m;
    logic        fb0;
    logic        fb1;
    int          errs;
    int          first_bad;
    m = 32'hACE1_2024;
    errs = 0;
    first_bad = -1;
    @(negedge clk);
    reset_d = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      fb0 = m[31] ^ m[21] ^ m[1] ^ m[0];
      m = {m[30:0], fb0};
      fb1 = m[31] ^ m[21] ^ m[1] ^ m[0];
      m = {m[30:0], fb1};
      @(posedge clk);
      #1;
      if (rand_d !== {fb0, fb1} || dut_d.s !== m) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
    end
    total++;
    if (errs != 0) $display("FAIL model_compare: got %0d mismatches (first at cycle %0d) want 0", errs, first_bad);
    else passed++;
  endtask

  task automatic test_distribution();
    int cnt [4];
    int run;
    int max_run;
    logic [1:0] prev;
    cnt = '{0, 0, 0, 0};
    run = 0;
    max_run = 0;
    prev = 2'bxx;
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk);
      #1;
      cnt[rand_d]++;
      run = (rand_d === prev) ? run + 1 : 1;
      if (run > max_run) max_run = run;
      prev = rand_d;
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (cnt[k] < 16384 - 600 || cnt[k] > 16384 + 600)
        $display("FAIL dist_code_%0d: got %0d occurrences want 16384+-600", k, cnt[k]);
      else passed++;
    end
    total++;
    if (max_run > 16) $display("FAIL dist_max_run: got %0d want <= 16", max_run);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_known();
    test_async_reset();
    test_lockup();
    test_model();
    test_distribution();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
